mmio_stream_fifo: RTL and testbench
===================================

// Module: mmio_stream_fifo
// PURPOSE
//  Circular-buffer FIFO between the AFU MMIO write decode (producer) and the MMIO read/compute path (consumer).
//  - Producer: one 64-bit push per host MMIO write to the data-window address.
//  - Consumer: pops words on request.
//  - Exposes fill level and sticky error flags so the AFU can map them to a status CSR.
// PARAMETERS
//  DW     64  data word width (bits)
//  DEPTH  8   number of entries; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, asynchronous, active-high
//  push       in   1      write push_data this cycle
//  push_data  in   DW     word to enqueue
//  pop        in   1      dequeue head word this cycle
//  pop_data   out  DW     registered head word from the last accepted pop
//  pop_valid  out  1      1-cycle pulse: pop_data updated
//  full       out  1      count == DEPTH
//  empty      out  1      count == 0
//  count      out  AW+1   current occupancy, 0..DEPTH
//  overflow   out  1      sticky: push rejected because full
//  underflow  out  1      sticky: pop rejected because empty
//  clr_err    in   1      synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset values: wr_ptr = rd_ptr = 0; count = 0; empty = 1; full = 0; pop_data = 0; pop_valid = 0; overflow = underflow = 0.
//    Storage contents are not reset.
//  - Pointers: AW bits, wrap DEPTH-1 -> 0. Occupancy is held in count, not derived from pointers.
//  - push_acc = push & (~full | pop_acc).
//    - Write lands in mem[wr_ptr] at clk edge; wr_ptr += 1.
//  - pop_acc = pop & ~empty.
//    - pop_data <= mem[rd_ptr]; rd_ptr += 1.
//    - pop_valid = 1 next cycle.
//    - Pop latency 1 clk.
//  - count update: +1 on push_acc only, -1 on pop_acc only, unchanged if both or neither.
//  - full/empty are registered, derived from the next-state count; they are valid in the same cycle as count.
//  - Simultaneous push & pop:
//    - Full: both accepted; count stays DEPTH; no overflow.
//    - Empty: pop rejected (underflow set); push accepted; count -> 1. No write-through bypass: pop_data is NOT the pushed word.
//    - Otherwise: both accepted; count unchanged.
//  - Rejected push: overflow <= 1; memory and pointers untouched.
//  - Rejected pop: underflow <= 1; pop_data holds its old value; pop_valid = 0.
//  - clr_err in the same cycle as a new error: the error wins (flag stays 1).
//  - No pop: pop_data holds its value indefinitely, so the AFU can re-read it over MMIO.
//  - rst asserted mid-operation: all state returns to reset values immediately. Entries are lost; no partial pop_valid.
// STRUCTURE
//  - Shared package afu_pkg holds: FIFO_DW = 64, FIFO_DEPTH = 8, typedef logic [63:0] t_fifo_word,
//    and the CSR address constants (data window h0020, status h0022) used by afu.
//  - One natural sub-module: fifo_mem_2p. Simple dual-port array, one write port, one registered read port, no reset.
//    Infers block/MLAB RAM.
//  - Control (pointers, count, flags) stays in mmio_stream_fifo.
// TESTING
//  1. Reset, then idle -> empty = 1, full = 0, count = 0, pop_data = 0, pop_valid = 0, flags = 0.
//  2. Push 1,2,3 (h11, h22, h33), then pop x3 -> pop_data h11, h22, h33 on consecutive cycles after each pop;
//     pop_valid high 3 cycles; empty = 1 at end.
//  3. Push 9 words (DEPTH = 8) -> full after the 8th; 9th rejected; overflow = 1; count = 8.
//     Then pop 8 -> first word out; last out = 8th pushed.
//  4. Full, then push h99 & pop together -> count stays 8, overflow stays 0.
//     Drain -> h99 emerges last, after pointer wrap.
//  5. Empty, then push hAA & pop together -> underflow = 1, pop_valid = 0, count = 1.
//     Next pop -> pop_data = hAA.
//  6. Push 5 words, assert rst mid-stream, release -> count = 0, empty = 1.
//     Pop -> underflow = 1. clr_err -> flags 0.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared AFU definitions: FIFO geometry, the FIFO word type and the CSR addresses
// through which the AFU exposes the stream FIFO to the host.
package afu_pkg;

  localparam int unsigned FIFO_DW    = 64;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef logic [63:0] t_fifo_word;

  // MMIO map: writes to the data window push a word; status mirrors level and flags.
  localparam logic [15:0] CSR_FIFO_DATA   = 16'h0020;
  localparam logic [15:0] CSR_FIFO_STATUS = 16'h0022;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block/MLAB RAM.
//   clk        clock
//   wr_en_i    write wr_data_i into mem[wr_addr_i]
//   rd_en_i    load rd_data_o from mem[rd_addr_i]; otherwise rd_data_o holds
//   rd_data_o  read register (old data when reading and writing the same address)
module fifo_mem_2p #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mmio_stream_fifo.sv
// Circular-buffer FIFO between the AFU MMIO write decode (producer) and the MMIO
// read/compute path (consumer).
//   clk, rst       clock; asynchronous active-high reset
//   push_i         enqueue push_data_i (accepted when not full, or when a pop frees a slot)
//   pop_i          dequeue head word (accepted when not empty)
//   pop_data_o     head word from the last accepted pop, held until the next one
//   pop_valid_o    1-cycle pulse when pop_data_o was updated
//   full_o/empty_o registered occupancy flags, aligned with count_o
//   count_o        occupancy 0..DEPTH
//   overflow_o     sticky: a push was rejected
//   underflow_o    sticky: a pop was rejected
//   clr_err_i      synchronous clear of both sticky flags (a new error wins)
module mmio_stream_fifo
  import afu_pkg::*;
#(
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            pop_data_o,
  output logic                     pop_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  input  logic                     clr_err_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          pop_valid_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  // Set by the first accepted pop after reset; until then the (unreset) RAM read
  // register is masked so pop_data_o reads as zero.
  logic          rd_seen_q;
  logic          push_acc, pop_acc;
  logic [DW-1:0] rd_data;

  assign pop_acc  = pop_i & ~empty_q;
  // A pop in the same cycle frees the slot the push needs when full.
  assign push_acc = push_i & (~full_q | pop_acc);

  always_comb begin
    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Error beats clear when both happen in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (push_i && !push_acc) begin
      overflow_d = 1'b1;
    end else if (clr_err_i) begin
      overflow_d = 1'b0;
    end
    underflow_d = underflow_q;
    if (pop_i && !pop_acc) begin
      underflow_d = 1'b1;
    end else if (clr_err_i) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q     <= count_d;
      full_q      <= (count_d == FullCount);
      empty_q     <= (count_d == '0);
      pop_valid_q <= pop_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_seen_q   <= rd_seen_q | pop_acc;
    end
  end

  fifo_mem_2p #(
    .Width (DW),
    .Depth (DEPTH),
    .AddrW (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (push_data_i),
    .rd_en_i   (pop_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign pop_data_o  = rd_seen_q ? rd_data : '0;
  assign pop_valid_o = pop_valid_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_mmio_stream_fifo.sv
// Bench for mmio_stream_fifo: directed scenarios followed by random traffic, all
// checked against a queue-based model of the FIFO's externally visible behaviour.
module tb_mmio_stream_fifo;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_valid, full, empty, overflow, underflow;
  logic [3:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_ovf, m_udf;

  mmio_stream_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (pop_data),
    .pop_valid_o (pop_valid),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .overflow_o  (overflow),
    .underflow_o (underflow),
    .clr_err_i   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic compare(input string where);
    int sz;
    sz = m_q.size();
    check({where, " count"},     DW'(count),     DW'(sz));
    check({where, " empty"},     DW'(empty),     DW'(sz == 0));
    check({where, " full"},      DW'(full),      DW'(sz == DEPTH));
    check({where, " pop_valid"}, DW'(pop_valid), DW'(m_valid));
    check({where, " pop_data"},  pop_data,       m_data);
    check({where, " overflow"},  DW'(overflow),  DW'(m_ovf));
    check({where, " underflow"}, DW'(underflow), DW'(m_udf));
  endtask

  // One clock cycle of stimulus; the model applies the FIFO rules at the edge.
  task automatic step(input string where, input bit ps, input bit pp,
                      input logic [DW-1:0] d, input bit clr);
    bit pop_ok, push_ok;
    push = ps; pop = pp; push_data = d; clr_err = clr;
    @(posedge clk);
    #1;
    pop_ok  = pp && (m_q.size() > 0);
    push_ok = ps && ((m_q.size() < DEPTH) || pop_ok);
    m_valid = pop_ok;
    if (pop_ok) m_data = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    if (ps && !push_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pp && !pop_ok) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    compare(where);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    compare("reset");
    step("idle", 0, 0, '0, 0);

    // Basic ordering
    step("t2 push", 1, 0, 64'h11, 0);
    step("t2 push", 1, 0, 64'h22, 0);
    step("t2 push", 1, 0, 64'h33, 0);
    for (int i = 0; i < 3; i++) step("t2 pop", 0, 1, '0, 0);
    step("t2 idle", 0, 0, '0, 0);
    check("t2 last word", pop_data, 64'h33);

    // Fill past capacity, then drain
    for (int i = 0; i < 9; i++) step("t3 push", 1, 0, 64'h100 + DW'(i), 0);
    check("t3 overflow", DW'(overflow), 64'd1);
    step("t3 pop first", 0, 1, '0, 0);
    check("t3 first out", pop_data, 64'h100);
    for (int i = 1; i < 8; i++) step("t3 pop", 0, 1, '0, 0);
    check("t3 last out", pop_data, 64'h107);
    step("t3 clr", 0, 0, '0, 1);

    // Simultaneous push/pop while full
    for (int i = 0; i < 8; i++) step("t4 fill", 1, 0, 64'h200 + DW'(i), 0);
    step("t4 push+pop full", 1, 1, 64'h99, 0);
    for (int i = 0; i < 8; i++) step("t4 drain", 0, 1, '0, 0);
    check("t4 h99 last", pop_data, 64'h99);

    // Simultaneous push/pop while empty: pop rejected, no bypass
    step("t5 push+pop empty", 1, 1, 64'hAA, 0);
    step("t5 pop", 0, 1, '0, 0);
    check("t5 pop_data", pop_data, 64'hAA);
    // Error wins over a same-cycle clear
    step("t5 err vs clr", 0, 1, '0, 1);
    step("t5 clr", 0, 0, '0, 1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step("t6 push", 1, 0, 64'h300 + DW'(i), 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare("t6 async rst");
    @(posedge clk);
    #1 rst = 1'b0;
    compare("t6 after rst");
    step("t6 pop empty", 0, 1, '0, 0);
    step("t6 clr", 0, 0, '0, 1);

    // Random traffic: push-heavy, balanced, then pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      int unsigned push_pct;
      push_pct = (i < 200) ? 75 : (i < 400) ? 50 : 25;
      step("rand", ($urandom_range(0, 99) < push_pct),
           ($urandom_range(0, 99) < (100 - push_pct)),
           {$urandom, $urandom}, ($urandom_range(0, 99) < 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
